// File: rtl/wb_arbiter_pkg.sv
// Shared widths, entry type and arbitration encoding for the write-back arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;
  localparam int ENTRY_W    = REG_ADDR_W + DATA_W;

  // One pending register-file write.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] waddr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  // Which source gets the last free slot when only one remains.
  typedef enum logic {
    FAV_MEM = 1'b0,
    FAV_ALU = 1'b1
  } favour_t;

endpackage

// File: rtl/wb_fifo.sv
// Two-write / one-read entry FIFO; wr0 is ordered ahead of wr1 within a cycle.
// Latency: a written entry is visible at rd_dat from the following cycle.
// Backpressure: none inside; the owner gates its sources on count so it never overfills.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr0_vld,
  input  logic [ENTRY_W-1:0]     wr0_dat,
  input  logic                   wr1_vld,
  input  logic [ENTRY_W-1:0]     wr1_dat,
  input  logic                   rd_vld,
  output logic [ENTRY_W-1:0]     rd_dat,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ENTRY_W-1:0] store [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr1_slot;

  // wr1 lands directly behind wr0 when both write, else at the write pointer.
  assign wr1_slot = wr_ptr + PTR_W'(wr0_vld);
  assign rd_dat   = store[rd_ptr];

  // Storage carries no reset: nothing is read unless count says it was written.
  always_ff @(posedge clock) begin
    if (wr0_vld) store[wr_ptr] <= wr0_dat;
    if (wr1_vld) store[wr1_slot] <= wr1_dat;
  end

  // Pointers wrap naturally at the power-of-two depth; count is one bit wider to tell full from empty.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(wr0_vld) + PTR_W'(wr1_vld);
      if (rd_vld) rd_ptr <= rd_ptr + PTR_W'(1);
      count  <= count + CNT_W'(wr0_vld) + CNT_W'(wr1_vld) - CNT_W'(rd_vld);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Merges ALU and load-unit results into one in-order register-file write port (optional WB_PENDING_EN).
// Latency: one cycle from transfer to W_en when empty; otherwise queued behind older entries.
// Backpressure: registered readies; both high with >=2 free slots, round-robin with 1, low when full.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_waddr,
  input  logic [DATA_W-1:0]     alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0]     mem_data,
  output logic                  W_en,
  output logic [REG_ADDR_W-1:0] Waddr,
  output logic [DATA_W-1:0]     Data_In,
  output logic [NUM_REGS-1:0]   pending,
  output logic                  idle
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  favour_t          favour;
  favour_t          favour_nxt;
  logic             alu_ready_nxt;
  logic             mem_ready_nxt;

  logic             alu_fire;
  logic             mem_fire;
  logic             alu_has;
  logic             mem_has;
  wb_entry_t        alu_e;
  wb_entry_t        mem_e;

  logic             first_vld;
  logic             second_vld;
  wb_entry_t        first_e;
  wb_entry_t        second_e;

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [CNT_W-1:0] free_cur;
  logic [CNT_W-1:0] free_nxt;
  logic             fifo_empty;
  logic             bypass;
  logic             wr0_vld;
  logic             wr1_vld;
  wb_entry_t        wr0_e;
  wb_entry_t        head_e;
  logic             load;
  wb_entry_t        load_e;

  assign alu_fire = alu_valid && alu_ready;
  assign mem_fire = mem_valid && mem_ready;

  // Register 0 is never written, so its transfers complete without producing an entry.
  assign alu_has  = alu_fire && (alu_waddr != '0);
  assign mem_has  = mem_fire && (mem_waddr != '0);
  assign alu_e    = '{waddr: alu_waddr, data: alu_data};
  assign mem_e    = '{waddr: mem_waddr, data: mem_data};

  // Compact this cycle's entries into an ordered pair: mem first, so a same-register alu result lands last.
  assign first_vld  = mem_has || alu_has;
  assign first_e    = mem_has ? mem_e : alu_e;
  assign second_vld = mem_has && alu_has;
  assign second_e   = alu_e;

  // An empty FIFO lets the oldest new entry skip straight into the output register.
  assign fifo_empty = (count == '0);
  assign bypass     = fifo_empty && first_vld;
  assign wr0_vld    = fifo_empty ? second_vld : first_vld;
  assign wr0_e      = fifo_empty ? second_e   : first_e;
  assign wr1_vld    = !fifo_empty && second_vld;

  // The output register drains the FIFO head whenever there is one, else takes the bypass entry.
  assign load   = !fifo_empty || bypass;
  assign load_e = fifo_empty ? first_e : head_e;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr0_vld (wr0_vld),
    .wr0_dat (wr0_e),
    .wr1_vld (wr1_vld),
    .wr1_dat (second_e),
    .rd_vld  (!fifo_empty),
    .rd_dat  (head_e),
    .count   (count)
  );

  // Next-cycle readies come from next-cycle occupancy so they leave a flop, never a valid.
  always_comb begin
    count_nxt     = count + CNT_W'(wr0_vld) + CNT_W'(wr1_vld) - CNT_W'(!fifo_empty);
    free_cur      = CNT_W'(FIFO_DEPTH) - count;
    free_nxt      = CNT_W'(FIFO_DEPTH) - count_nxt;
    favour_nxt    = favour;
    if (free_cur == CNT_W'(1)) begin
      if ((favour == FAV_MEM) && mem_fire) favour_nxt = FAV_ALU;
      if ((favour == FAV_ALU) && alu_fire) favour_nxt = FAV_MEM;
    end
    alu_ready_nxt = 1'b0;
    mem_ready_nxt = 1'b0;
    if (free_nxt >= CNT_W'(2)) begin
      alu_ready_nxt = 1'b1;
      mem_ready_nxt = 1'b1;
    end else if (free_nxt == CNT_W'(1)) begin
      alu_ready_nxt = (favour_nxt == FAV_ALU);
      mem_ready_nxt = (favour_nxt == FAV_MEM);
    end
  end

  // Arbitration state: round-robin favour plus the registered readies it drives.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      favour    <= FAV_MEM;
      alu_ready <= 1'b0;
      mem_ready <= 1'b0;
    end else begin
      favour    <= favour_nxt;
      alu_ready <= alu_ready_nxt;
      mem_ready <= mem_ready_nxt;
    end
  end

  // Register-file write port; address and data hold when no write is issued.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      W_en    <= 1'b0;
      Waddr   <= '0;
      Data_In <= '0;
    end else begin
      W_en <= load;
      if (load) begin
        Waddr   <= load_e.waddr;
        Data_In <= load_e.data;
      end
    end
  end

  assign idle = fifo_empty && !W_en;

`ifdef WB_PENDING_EN
  localparam int PEND_W = $clog2(FIFO_DEPTH + 2);

  logic [PEND_W-1:0] pend_cnt [NUM_REGS];
  logic [1:0]        pend_inc [NUM_REGS];
  logic              pend_dec [NUM_REGS];

  // Count entries entering per register and the one leaving the output register this cycle.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      pend_inc[r] = 2'(first_vld  && (first_e.waddr  == REG_ADDR_W'(r)))
                  + 2'(second_vld && (second_e.waddr == REG_ADDR_W'(r)));
      pend_dec[r] = W_en && (Waddr == REG_ADDR_W'(r));
    end
  end

  // Outstanding writes per register, covering both FIFO contents and the output register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) pend_cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        pend_cnt[r] <= pend_cnt[r] + PEND_W'(pend_inc[r]) - PEND_W'(pend_dec[r]);
      end
    end
  end

  // A register is pending while any of its writes is still outstanding.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) pending[r] = (pend_cnt[r] != '0);
  end
`else
  assign pending = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready, mem_valid, mem_ready;
  logic [4:0]  alu_waddr, mem_waddr, Waddr;
  logic [31:0] alu_data, mem_data, Data_In, pending;
  logic        W_en, idle;

  wb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_waddr (alu_waddr),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_waddr (mem_waddr),
    .mem_data  (mem_data),
    .W_en      (W_en),
    .Waddr     (Waddr),
    .Data_In   (Data_In),
    .pending   (pending),
    .idle      (idle)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: queue of accepted, not-yet-written entries, plus the expected write port.
  wb_entry_t   q[$];
  logic        m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_data;
  logic        m_fav;            // 0: mem gets the last slot, 1: alu does
  logic        m_ar, m_mr;       // readies expected for the coming cycle
  logic        pre_ar, pre_mr;   // readies expected during the cycle just stepped
  logic        obs_ar, obs_mr;   // readies seen during the cycle just stepped

  task automatic model_reset();
    q.delete();
    m_wen = 1'b0; m_waddr = '0; m_data = '0;
    m_fav = 1'b0; m_ar = 1'b0; m_mr = 1'b0;
  endtask

  task automatic model_edge(input logic af, input logic [4:0] aa, input logic [31:0] ad,
                            input logic mf, input logic [4:0] ma, input logic [31:0] md);
    wb_entry_t e;
    int free_b;
    free_b = DEPTH - q.size();
    if (free_b == 1) begin
      if (!m_fav && mf) m_fav = 1'b1;
      else if (m_fav && af) m_fav = 1'b0;
    end
    if (mf && ma != 0) begin e.waddr = ma; e.data = md; q.push_back(e); end
    if (af && aa != 0) begin e.waddr = aa; e.data = ad; q.push_back(e); end
    if (q.size() > 0) begin
      e = q.pop_front();
      m_wen = 1'b1; m_waddr = e.waddr; m_data = e.data;
    end else begin
      m_wen = 1'b0;
    end
    free_b = DEPTH - q.size();
    m_ar = (free_b >= 2) || (free_b == 1 && m_fav);
    m_mr = (free_b >= 2) || (free_b == 1 && !m_fav);
  endtask

  function automatic logic [31:0] exp_pending();
    logic [31:0] m;
    m = '0;
`ifdef WB_PENDING_EN
    foreach (q[i]) m[q[i].waddr] = 1'b1;
    if (m_wen) m[m_waddr] = 1'b1;
`endif
    return m;
  endfunction

  function automatic logic exp_idle();
    return (q.size() == 0) && !m_wen;
  endfunction

  // Drive one cycle from a negedge, update the model at the posedge, return at the next negedge.
  task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic mv, input logic [4:0] ma, input logic [31:0] md);
    alu_valid = av; alu_waddr = aa; alu_data = ad;
    mem_valid = mv; mem_waddr = ma; mem_data = md;
    #1;
    obs_ar = alu_ready; obs_mr = mem_ready;
    pre_ar = m_ar;      pre_mr = m_mr;
    @(posedge clock);
    model_edge(av && pre_ar, aa, ad, mv && pre_mr, ma, md);
    @(negedge clock);
    alu_valid = 1'b0; mem_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clock);
    vectors++; if (W_en !== 1'b0) begin miscompares++; $display("FAIL reset_wen: got %0h expected 0", W_en); end
    vectors++; if (Waddr !== 5'd0) begin miscompares++; $display("FAIL reset_waddr: got %0h expected 0", Waddr); end
    vectors++; if (Data_In !== 32'd0) begin miscompares++; $display("FAIL reset_data: got %0h expected 0", Data_In); end
    vectors++; if (pending !== 32'd0) begin miscompares++; $display("FAIL reset_pending: got %0h expected 0", pending); end
    vectors++; if (idle !== 1'b1) begin miscompares++; $display("FAIL reset_idle: got %0h expected 1", idle); end
    reset = 1'b0;
    step(0, 0, 0, 0, 0, 0);
    vectors++; if (W_en !== 1'b0) begin miscompares++; $display("FAIL post_reset_wen: got %0h expected 0", W_en); end
    step(0, 0, 0, 0, 0, 0);
    vectors++; if ({obs_ar, obs_mr} !== {pre_ar, pre_mr}) begin miscompares++; $display("FAIL post_reset_ready: got %b expected %b", {obs_ar, obs_mr}, {pre_ar, pre_mr}); end
    vectors++; if ({obs_ar, obs_mr} !== 2'b11) begin miscompares++; $display("FAIL empty_ready: got %b expected 11", {obs_ar, obs_mr}); end
  endtask

  task automatic test_single();
    step(1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
    vectors++; if (W_en !== 1'b1) begin miscompares++; $display("FAIL single_wen: got %0h expected 1", W_en); end
    vectors++; if (Waddr !== 5'd5) begin miscompares++; $display("FAIL single_waddr: got %0d expected 5", Waddr); end
    vectors++; if (Data_In !== 32'hDEADBEEF) begin miscompares++; $display("FAIL single_data: got %h expected deadbeef", Data_In); end
    vectors++; if (pending !== exp_pending()) begin miscompares++; $display("FAIL single_pending: got %h expected %h", pending, exp_pending()); end
    step(0, 0, 0, 0, 0, 0);
    vectors++; if (W_en !== 1'b0) begin miscompares++; $display("FAIL single_after_wen: got %0h expected 0", W_en); end
    vectors++; if (idle !== 1'b1) begin miscompares++; $display("FAIL single_after_idle: got %0h expected 1", idle); end
  endtask

  task automatic test_dual();
    logic [31:0] exp_d [2];
    exp_d[0] = 32'h1; exp_d[1] = 32'h2;
    step(1, 5'd3, 32'h2, 1, 5'd3, 32'h1);
    vectors++; if ({obs_ar, obs_mr} !== 2'b11) begin miscompares++; $display("FAIL dual_ready: got %b expected 11", {obs_ar, obs_mr}); end
    for (int i = 0; i < 2; i++) begin
      vectors++; if (W_en !== 1'b1 || Waddr !== 5'd3 || Data_In !== exp_d[i]) begin
        miscompares++; $display("FAIL dual_write%0d: got en=%0h addr=%0d data=%h expected en=1 addr=3 data=%h", i, W_en, Waddr, Data_In, exp_d[i]);
      end
      vectors++; if (pending !== exp_pending()) begin miscompares++; $display("FAIL dual_pending%0d: got %h expected %h", i, pending, exp_pending()); end
      step(0, 0, 0, 0, 0, 0);
    end
    vectors++; if (W_en !== 1'b0) begin miscompares++; $display("FAIL dual_done_wen: got %0h expected 0", W_en); end
    vectors++; if (pending !== 32'd0) begin miscompares++; $display("FAIL dual_pending_clear: got %h expected 0", pending); end
  endtask

  task automatic test_zero_addr();
    step(1, 5'd0, 32'h12345678, 0, 0, 0);
    vectors++; if (obs_ar !== 1'b1) begin miscompares++; $display("FAIL zero_ready: got %0h expected 1", obs_ar); end
    vectors++; if (W_en !== 1'b0) begin miscompares++; $display("FAIL zero_wen: got %0h expected 0", W_en); end
    vectors++; if (idle !== 1'b1) begin miscompares++; $display("FAIL zero_idle: got %0h expected 1", idle); end
  endtask

  task automatic test_saturation();
    int single_grants;
    single_grants = 0;
    for (int c = 0; c < 48; c++) begin
      step(1, 5'($urandom_range(1, 31)), $urandom, 1, 5'($urandom_range(1, 31)), $urandom);
      if (pre_ar ^ pre_mr) single_grants++;
      vectors++; if ({obs_ar, obs_mr} !== {pre_ar, pre_mr}) begin miscompares++; $display("FAIL sat_ready c%0d: got %b expected %b", c, {obs_ar, obs_mr}, {pre_ar, pre_mr}); end
      vectors++; if (W_en !== m_wen || (m_wen && (Waddr !== m_waddr || Data_In !== m_data))) begin
        miscompares++; $display("FAIL sat_write c%0d: got en=%0h addr=%0d data=%h expected en=%0h addr=%0d data=%h", c, W_en, Waddr, Data_In, m_wen, m_waddr, m_data);
      end
      vectors++; if (pending !== exp_pending()) begin miscompares++; $display("FAIL sat_pending c%0d: got %h expected %h", c, pending, exp_pending()); end
    end
    vectors++; if (single_grants < 10) begin miscompares++; $display("FAIL sat_throttle: got %0d single-source cycles expected at least 10", single_grants); end
    for (int c = 0; c < DEPTH + 2; c++) begin
      step(0, 0, 0, 0, 0, 0);
      vectors++; if (W_en !== m_wen || (m_wen && (Waddr !== m_waddr || Data_In !== m_data))) begin
        miscompares++; $display("FAIL sat_drain c%0d: got en=%0h addr=%0d data=%h expected en=%0h addr=%0d data=%h", c, W_en, Waddr, Data_In, m_wen, m_waddr, m_data);
      end
    end
    vectors++; if (idle !== 1'b1) begin miscompares++; $display("FAIL sat_idle: got %0h expected 1", idle); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 9) < 7, 5'($urandom_range(0, 31)), $urandom,
           $urandom_range(0, 9) < 6, 5'($urandom_range(0, 31)), $urandom);
      vectors++; if ({obs_ar, obs_mr} !== {pre_ar, pre_mr}) begin miscompares++; $display("FAIL rnd_ready c%0d: got %b expected %b", c, {obs_ar, obs_mr}, {pre_ar, pre_mr}); end
      vectors++; if (W_en !== m_wen || (m_wen && (Waddr !== m_waddr || Data_In !== m_data))) begin
        miscompares++; $display("FAIL rnd_write c%0d: got en=%0h addr=%0d data=%h expected en=%0h addr=%0d data=%h", c, W_en, Waddr, Data_In, m_wen, m_waddr, m_data);
      end
      vectors++; if (pending !== exp_pending()) begin miscompares++; $display("FAIL rnd_pending c%0d: got %h expected %h", c, pending, exp_pending()); end
      vectors++; if (idle !== exp_idle()) begin miscompares++; $display("FAIL rnd_idle c%0d: got %0h expected %0h", c, idle, exp_idle()); end
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    guard = 0;
    while (q.size() < 3 && guard < 20) begin
      step(1, 5'($urandom_range(1, 31)), $urandom, 1, 5'($urandom_range(1, 31)), $urandom);
      guard++;
    end
    vectors++; if (W_en !== 1'b1) begin miscompares++; $display("FAIL mid_busy_wen: got %0h expected 1", W_en); end
    #2 reset = 1'b1;
    #1;
    model_reset();
    vectors++; if (W_en !== 1'b0 || Waddr !== 5'd0 || Data_In !== 32'd0) begin
      miscompares++; $display("FAIL mid_reset_port: got en=%0h addr=%0d data=%h expected all 0", W_en, Waddr, Data_In);
    end
    vectors++; if (pending !== 32'd0) begin miscompares++; $display("FAIL mid_reset_pending: got %h expected 0", pending); end
    vectors++; if (idle !== 1'b1) begin miscompares++; $display("FAIL mid_reset_idle: got %0h expected 1", idle); end
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step(0, 0, 0, 0, 0, 0);
      vectors++; if (W_en !== 1'b0) begin miscompares++; $display("FAIL mid_release_wen c%0d: got %0h expected 0", c, W_en); end
    end
    step(1, 5'd7, 32'hCAFE0007, 0, 0, 0);
    vectors++; if (W_en !== 1'b1 || Waddr !== 5'd7 || Data_In !== 32'hCAFE0007) begin
      miscompares++; $display("FAIL mid_new_write: got en=%0h addr=%0d data=%h expected en=1 addr=7 data=cafe0007", W_en, Waddr, Data_In);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    alu_valid = 1'b0; alu_waddr = '0; alu_data = '0;
    mem_valid = 1'b0; mem_waddr = '0; mem_data = '0;
    test_reset();
    test_single();
    test_dual();
    test_zero_addr();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
